// File: rtl/pipe_stage_reg_pkg.sv
// Shared helpers for the parametrised pipeline stage register.
// The entry layout is a macro because packages cannot hold parameterised typedefs.
`ifndef PIPE_ENTRY_T
`define PIPE_ENTRY_T(SW, DW) struct packed { logic valid; logic [(SW)-1:0] src; logic [(DW)-1:0] data; }
`endif

package pipe_stage_reg_pkg;

  // Index width for n selectable banks, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for stage performance debug.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: banked payload capture, valid/ready handshake with
// optional skid entry, flush, and saturating stall/bubble counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W  = 160,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned SKID    = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [sel_width(NUM_SRC)-1:0]      in_sel,
  input  logic [NUM_SRC*DATA_W-1:0]          in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_W-1:0]                  out_data,
  output logic [sel_width(NUM_SRC)-1:0]      out_src,
  output logic [CNT_W-1:0]                   stall_cnt,
  output logic [CNT_W-1:0]                   bubble_cnt
);

  localparam int unsigned SEL_W = sel_width(NUM_SRC);

  typedef `PIPE_ENTRY_T(SEL_W, DATA_W) entry_t;

  entry_t cap;
  entry_t main_q;
  logic   accept;

  // Out-of-range selects fall through to bank 0 with src 0.
  always_comb begin
    cap       = '0;
    cap.valid = 1'b1;
    cap.data  = in_data[DATA_W-1:0];
    for (int unsigned k = 1; k < NUM_SRC; k++) begin
      if (in_sel == SEL_W'(k)) begin
        cap.src  = SEL_W'(k);
        cap.data = in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign accept = in_valid & in_ready & ~flush;

  if (SKID != 0) begin : g_skid
    entry_t skid_q;

    assign in_ready = ~skid_q.valid;

    // Skid only fills while main is stalled, so main always drains it first.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_q <= '0;
        skid_q <= '0;
      end else if (flush) begin
        main_q <= '0;
        skid_q <= '0;
      end else if (!main_q.valid || out_ready) begin
        main_q <= skid_q.valid ? skid_q : (accept ? cap : entry_t'('0));
        skid_q <= '0;
      end else if (accept) begin
        skid_q <= cap;
      end
    end
  end else begin : g_noskid
    assign in_ready = ~main_q.valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_q <= '0;
      end else if (flush) begin
        main_q <= '0;
      end else if (accept) begin
        main_q <= cap;
      end else if (out_ready) begin
        main_q <= '0;
      end
    end
  end

  assign out_valid = main_q.valid;
  assign out_data  = main_q.valid ? main_q.data : '0;
  assign out_src   = main_q.valid ? main_q.src  : '0;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (main_q.valid & ~out_ready),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~main_q.valid),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one SKID=1/NUM_SRC=3 and one SKID=0/NUM_SRC=2 instance.
`timescale 1ns/1ps
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int unsigned SK   = (g == 0) ? 1 : 0;
    localparam int unsigned NS   = (g == 0) ? 3 : 2;
    localparam int unsigned CW   = (g == 0) ? 5 : 4;
    localparam int unsigned SW   = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [SW-1:0]  in_sel = '0;
    logic [SW-1:0]  out_src;
    logic [NS*DW-1:0] in_data = '0;
    logic [DW-1:0]  out_data;
    logic [CW-1:0]  stall_cnt;
    logic [CW-1:0]  bubble_cnt;

    logic [DW-1:0]  bank [NS];
    logic [DW-1:0]  qd [$];
    logic [SW-1:0]  qs [$];
    int unsigned    stall_m = 0;
    int unsigned    bubble_m = 0;
    int unsigned    occ;
    logic           done_i = 1'b0;

    pipe_stage_reg #(.DATA_W(DW), .NUM_SRC(NS), .SKID(SK), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sel     (in_sel),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_src    (out_src),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
    );

    function automatic string nm(input string s);
      return $sformatf("cfg%0d_%s", g, s);
    endfunction

    // Model: the stage is an ordered queue holding at most 1 (SKID=0) or 2 beats.
    always @(negedge clk) begin
      #1;
      if (rst) begin
        chk(nm("rst_valid"), out_valid, 0);
        chk(nm("rst_data"), out_data, 0);
        chk(nm("rst_ready"), in_ready, 1);
        chk(nm("rst_stall"), stall_cnt, 0);
        chk(nm("rst_bubble"), bubble_cnt, 0);
        qd.delete();
        qs.delete();
        stall_m  = 0;
        bubble_m = 0;
      end else begin
        occ = qd.size();
        chk(nm("out_valid"), out_valid, occ > 0);
        chk(nm("in_ready"), in_ready, (SK != 0) ? (occ < 2) : (occ == 0 || out_ready));
        if (occ > 0) begin
          chk(nm("out_data"), out_data, qd[0]);
          chk(nm("out_src"), out_src, qs[0]);
        end else begin
          chk(nm("idle_data"), out_data, 0);
          chk(nm("idle_src"), out_src, 0);
        end
        chk(nm("stall_cnt"), stall_cnt, stall_m);
        chk(nm("bubble_cnt"), bubble_cnt, bubble_m);
        if (occ > 0 && !out_ready && stall_m < CMAX) stall_m++;
        if (occ == 0 && bubble_m < CMAX) bubble_m++;
        if (flush) begin
          qd.delete();
          qs.delete();
        end else if (occ > 0 && out_ready) begin
          void'(qd.pop_front());
          void'(qs.pop_front());
        end
      end
    end

    task automatic cycle(input logic r, input logic iv, input logic [SW-1:0] sel,
                         input logic fl, input logic ordy, output logic acc);
      int unsigned eff;
      @(negedge clk);
      rst       = r;
      in_valid  = iv;
      in_sel    = sel;
      flush     = fl;
      out_ready = ordy;
      for (int unsigned k = 0; k < NS; k++) in_data[k*DW +: DW] = bank[k];
      #2;
      acc = iv && in_ready && !fl && !r;
      if (acc) begin
        eff = (sel < NS) ? sel : 0;
        qd.push_back(bank[eff]);
        qs.push_back(SW'(eff));
      end
    endtask

    task automatic rand_banks();
      for (int unsigned k = 0; k < NS; k++) bank[k] = $urandom;
    endtask

    initial begin
      logic a;
      int   beat;
      int   c;
      for (int unsigned k = 0; k < NS; k++) bank[k] = '0;

      repeat (2) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, a);
      repeat (40) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, a);
      chk(nm("bubble_sat"), bubble_cnt, CMAX);

      // bank select
      repeat (2) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, a);
      bank[0] = 32'h5A5A5A5A;
      bank[1] = 32'hA5A5A5A5;
      if (NS > 2) bank[2] = 32'h33333333;
      cycle(1'b0, 1'b1, SW'(1), 1'b0, 1'b1, a);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, a);
      chk(nm("bank1_data"), out_data, 32'hA5A5A5A5);
      chk(nm("bank1_src"), out_src, 1);
      cycle(1'b0, 1'b1, SW'(3), 1'b0, 1'b1, a);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, a);

      // backpressure: beats 1..6, out_ready low in cycles 3-5
      repeat (2) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, a);
      beat = 1;
      c = 1;
      while (beat <= 6 && c < 50) begin
        for (int unsigned k = 0; k < NS; k++) bank[k] = DW'(beat) | (DW'(k) << 16);
        cycle(1'b0, 1'b1, '0, 1'b0, !(c >= 3 && c <= 5), a);
        if (a) beat++;
        c++;
      end
      repeat (4) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, a);
      chk(nm("bp_stall"), stall_cnt, 3);

      // back-to-back stream: only the first cycle after reset is a bubble
      repeat (2) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, a);
      repeat (20) begin
        rand_banks();
        cycle(1'b0, 1'b1, SW'($urandom_range(0, (1 << SW) - 1)), 1'b0, 1'b1, a);
      end
      chk(nm("b2b_bubble"), bubble_cnt, 1);

      // flush with a beat offered while full
      repeat (3) begin
        rand_banks();
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0, a);
      end
      for (int unsigned k = 0; k < NS; k++) bank[k] = 32'hDEADBEEF;
      cycle(1'b0, 1'b1, '0, 1'b1, 1'b0, a);
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, a);
      chk(nm("flush_valid"), out_valid, 0);
      chk(nm("flush_data"), out_data, 0);
      repeat (3) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, a);

      // asynchronous reset while full and stalled
      repeat (3) begin
        rand_banks();
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0, a);
      end
      @(posedge clk);
      #2;
      chk(nm("pre_rst_valid"), out_valid, 1);
      rst = 1'b1;
      #1;
      chk(nm("arst_valid"), out_valid, 0);
      chk(nm("arst_data"), out_data, 0);
      chk(nm("arst_ready"), in_ready, 1);
      chk(nm("arst_stall"), stall_cnt, 0);
      chk(nm("arst_bubble"), bubble_cnt, 0);
      repeat (2) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, a);

      // randomized traffic with occasional flush
      repeat (400) begin
        rand_banks();
        cycle(1'b0, $urandom_range(0, 3) != 0, SW'($urandom_range(0, (1 << SW) - 1)),
              $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, a);
      end
      repeat (5) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, a);
      done_i = 1'b1;
    end
  end

  initial begin
    fork
      wait (g_cfg[0].done_i && g_cfg[1].done_i);
      begin
        #200000;
        fails++;
        $display("FAIL watchdog: stimulus incomplete, expected completion by 200000 ns");
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed per-stage registers between decode/execute and later stages. It carries an opaque payload bus selected from one of NUM_SRC source banks (e.g. normal vs. divide micro-op controls), uses a valid/ready handshake with an optional skid entry, and supports flush. When out_valid is low the payload is forced to zero, so that downstream decoders see a NOP. It also keeps saturating stall and bubble counters for performance debug.

## Interface
- DATA_W, 160, payload width per source bank (PC, operands, control fields packed by the instantiating stage)
- NUM_SRC, 2, number of selectable payload source banks (≥1)
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- CNT_W, 16, width of each performance counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  kills all held entries and discards the input beat this cycle
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat
- in_sel  in  max(1,$clog2(NUM_SRC))  source bank index; values ≥ NUM_SRC select bank 0
- in_data  in  NUM_SRC*DATA_W  bank k occupies bits [k*DATA_W +: DATA_W]
- out_valid  out  1  beat presented downstream
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  selected payload; all-zero when out_valid=0
- out_src  out  max(1,$clog2(NUM_SRC))  bank index the beat came from; 0 when out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
- bubble_cnt  out  CNT_W  cycles with out_valid=0

## Operation
- Accept: in_valid & in_ready & ~flush. Bank mux is applied at capture; only DATA_W bits are stored per entry.
- Entries: main (drives outputs) and, if SKID=1, skid. Each entry holds valid, data, src.
- SKID=0: in_ready = ~main_valid | out_ready. Accepted beats load main. If out_ready with no accept, main_valid clears.
- SKID=1: in_ready = ~skid_valid (register output, no combinational path from out_ready).
  - Main empty or out_ready: main loads skid if skid_valid, else the accepted beat, else becomes invalid. Skid clears.
  - Main full and ~out_ready: an accepted beat goes to skid.
  - Skid full and ~out_ready: hold everything.
- Flush: all valids clear and stored data/src zero on the next edge. The input beat is discarded even if in_valid & in_ready. Flush overrides out_ready and accept.
- Invalid entries always hold zero data/src. out_data/out_src are zero whenever out_valid=0.
- Counters: increment by 1 per qualifying cycle and saturate at all-ones. They are cleared only by rst and are not cleared by flush.
- Reset (asserted at any time, including mid-transfer or mid-stall): all valids 0, data/src 0, both counters 0. in_ready = 1 after reset (both modes). out_valid = 0 and out_data = 0 immediately (asynchronous).

## Timing
- Latency: a beat accepted at edge N appears on out_valid/out_data after edge N when the stage is empty.
- Throughput: 1 beat/cycle sustained with out_ready held high, both modes.
- SKID=1: after out_ready falls, one further beat is absorbed. in_ready drops the cycle after skid fills and rises the cycle after skid drains.
- Simultaneous accept and out_ready with main full (SKID=0): the new beat replaces main in the same edge with no bubble.
- Counters reflect the state of the previous cycle (registered increment).

## Structure
- Shared package: sel_width function max(1,$clog2(n)), and the entry struct {valid, src, data} as a parameterised type or macro. Payload field offsets belong to the instantiating stage's package, not here.
- One natural sub-module, pipe_sat_counter (CNT_W, inc, saturating), instantiated twice.
- Skid logic is a generate branch on SKID inside this module.

## Test plan
- Reset mid-stream: SKID=1 with both entries full and rst pulsed asynchronously -> out_valid=0, out_data=0, in_ready=1, counters 0 without waiting for a clock edge.
- Bank select: NUM_SRC=2, in_sel=1, bank1=0xA5.., bank0=0x5A.. -> next cycle out_data = bank1 value, out_src=1. in_sel=3 with NUM_SRC=3 -> bank 0 captured.
- Backpressure with SKID=1: stream beats 1..6, out_ready low for cycles 3–5 -> in_ready falls one cycle after the skid fills, no beat lost or duplicated, output order 1..6, stall_cnt=3.
- Flush with a beat offered: main and skid full, flush=1, in_valid=1 -> next cycle out_valid=0, out_data=0, and the offered beat never appears.
- Back-to-back with SKID=0: out_ready=1 and a continuous stream -> out_valid is 1 every cycle after the first, bubble_cnt stops increasing.
- Counter saturation: CNT_W=4, idle for 20 cycles -> bubble_cnt=15 and holds.
